// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMulCap,
    StDivRun,
    StDivFix
  } state_e;

endpackage

// File: rtl/hilo_div32.sv
// Unsigned restoring divider core: one quotient bit per step, magnitudes only.
module hilo_div32
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] quot,
  output logic             last
);

  localparam int unsigned CntW = $clog2(DIV_STEPS) + 1;

  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   shifted, diff;

  // Extra top bit keeps the shifted partial remainder from overflowing.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dvsr_d = divisor;
      cnt_d  = '0;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_d  = diff[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = shifted[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rem  = rem_q;
  assign quot = quot_q;
  assign last = step && (cnt_q == CntW'(DIV_STEPS - 1));

endmodule

// File: rtl/hilo_unit.sv
// Multiply/divide sequencer and architectural HI/LO registers with busy/done handshake.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   mul_x,
  output logic [WIDTH-1:0]   mul_y,
  input  logic [2*WIDTH-1:0] mul_z,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic             done_q, done_d;
  logic             neg_rem_q, neg_rem_d, neg_quot_q, neg_quot_d;
  logic             zero_q, zero_d;

  logic             div_load, div_step, div_last;
  logic [WIDTH-1:0] div_a, div_b, div_rem, div_quot;

  hilo_div32 #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (div_load),
    .step    (div_step),
    .dividend(div_a),
    .divisor (div_b),
    .rem     (div_rem),
    .quot    (div_quot),
    .last    (div_last)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mul_x_d    = mul_x_q;
    mul_y_d    = mul_y_q;
    done_d     = 1'b0;
    neg_rem_d  = neg_rem_q;
    neg_quot_d = neg_quot_q;
    zero_d     = zero_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
    div_a      = rs[WIDTH-1] ? -rs : rs;
    div_b      = rt[WIDTH-1] ? -rt : rt;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            OP_MULT: begin
              mul_x_d = rs;
              mul_y_d = rt;
              state_d = StMulCap;
            end
            OP_DIV: begin
              div_load = 1'b1;
              if (rt == '0) begin
                // Divide-by-zero parks rs in the quotient register so DivFix can return it.
                zero_d  = 1'b1;
                div_a   = rs;
                state_d = StDivFix;
              end else begin
                zero_d     = 1'b0;
                neg_rem_d  = rs[WIDTH-1];
                neg_quot_d = rs[WIDTH-1] ^ rt[WIDTH-1];
                state_d    = StDivRun;
              end
            end
            OP_MTHI: begin
              hi_d   = rs;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = rs;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StMulCap: begin
        {hi_d, lo_d} = mul_z;
        done_d       = 1'b1;
        state_d      = StIdle;
      end
      StDivRun: begin
        div_step = 1'b1;
        if (div_last) state_d = StDivFix;
      end
      StDivFix: begin
        if (zero_q) begin
          hi_d = div_quot;
          lo_d = '1;
        end else begin
          lo_d = neg_quot_q ? -div_quot : div_quot;
          hi_d = neg_rem_q ? -div_rem : div_rem;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_x_q    <= '0;
      mul_y_q    <= '0;
      done_q     <= 1'b0;
      neg_rem_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_x_q    <= mul_x_d;
      mul_y_q    <= mul_y_d;
      done_q     <= done_d;
      neg_rem_q  <= neg_rem_d;
      neg_quot_q <= neg_quot_d;
      zero_q     <= zero_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign mul_x = mul_x_q;
  assign mul_y = mul_y_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
